mux_scan_seq: RTL and testbench

Scan sequencer that drives the 2-bit select of the 4:1 gate-level multiplexer and captures its single-bit output. It steps the select through channels 0..3 and waits a programmable settle time on each channel before sampling. The four samples are assembled into one 4-bit snapshot, presented with a one-cycle valid strobe and a change flag. The block sits directly upstream (select) and downstream (output) of the mux, turning a 1-bit mux path back into a parallel word.

---
 rtl/mux_scan_seq.sv | 175 +++++++++++++++++
 tb/tb_mux_scan_seq.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_seq.sv
// -----------------------------------------------------------------------------
// mux_scan_seq
//
// Scan sequencer for a 4:1 single-bit multiplexer. It steps the mux select
// through channels 0..3 and holds each channel for SETTLE cycles before it
// samples the mux output on one extra SAMPLE cycle. The four samples form one
// 4-bit snapshot. The snapshot is published with a one-cycle valid strobe and
// a flag that shows whether it differs from the previous snapshot. The block
// turns a serial 1-bit mux path back into a parallel word.
//
// Frame timing (E0 = edge that accepts start):
//   - channel n is driven on sel for SETTLE+1 cycles
//   - channel n is sampled at edge E0 + (n+1)*(SETTLE+1)
//   - valid is high in the cycle after edge E0 + 4*(SETTLE+1) (the DONE cycle)
//   - in continuous mode the next frame's E0 is the DONE-closing edge, so
//     the frame period is 4*(SETTLE+1)+1 cycles
//
// Parameters:
//   SETTLE   cycles the select is held before sampling, legal range 1..15
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous, active-high reset (priority over all inputs)
//   start    in   request one scan frame; only looked at in IDLE
//   cont     in   continuous mode; only looked at in DONE
//   mux_o    in   output of the 4:1 mux
//   sel      out  [1:0] mux select (bit 1 -> s[1], bit 0 -> s[0])
//   data     out  [3:0] last completed snapshot, data[n] = mux_o with sel=n
//   valid    out  one-cycle strobe, new snapshot on data
//   changed  out  qualified by valid: snapshot differs from the previous one
//   busy     out  frame in progress (SETTLE, SAMPLE or DONE)
//
// All outputs come from registers. There is no combinational path from any
// input to any output.
// -----------------------------------------------------------------------------
module mux_scan_seq #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       mux_o,
  output logic [1:0] sel,
  output logic [3:0] data,
  output logic       valid,
  output logic       changed,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // The settle count runs 0..SETTLE-1. The count leaves SETTLE on its last value.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [1:0] LAST_CH     = 2'd3;

  state_t     state;
  state_t     next_state;
  logic [3:0] cnt;
  logic [2:0] shadow;     // channels 0..2, held until channel 3 completes the word
  logic       have_prev;  // a previous snapshot exists for the change compare
  logic [3:0] new_word;

  // The word that is assembled at the closing edge of the last SAMPLE cycle.
  assign new_word = {mux_o, shadow};

  // busy is decoded from the state register only, so it stays a registered output.
  assign busy = (state != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: assign the default first so that every path through the case writes next_state; no latch is inferred.
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          next_state = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        next_state = (sel == LAST_CH) ? ST_DONE : ST_SETTLE;
      end
      ST_DONE: begin
        next_state = cont ? ST_SETTLE : ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. Every register then updates from pre-edge values, so the order of statements does not matter.
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: settle counter, select, shadow samples, snapshot and flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shadow samples are also reset. A frame aborted by reset then leaves no partial word that could leak into a later snapshot.
      cnt       <= '0;
      sel       <= '0;
      shadow    <= '0;
      data      <= '0;
      valid     <= 1'b0;
      changed   <= 1'b0;
      have_prev <= 1'b0;
    end else begin
      // valid is a strobe. It is set only on the edge that enters DONE.
      valid <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            cnt <= '0;
            sel <= '0;
          end
        end

        ST_SETTLE: begin
          cnt <= cnt + 4'd1;
        end

        ST_SAMPLE: begin
          if (sel != LAST_CH) begin
            shadow[sel] <= mux_o;
            sel         <= sel + 2'd1;
            cnt         <= '0;
          end else begin
            // Publish the whole word at once. data is never partly updated.
            data      <= new_word;
            changed   <= have_prev && (new_word != data);
            have_prev <= 1'b1;
            valid     <= 1'b1;
            sel       <= '0;
          end
        end

        ST_DONE: begin
          // sel already wrapped to 0 at the SAMPLE edge. A continuous frame
          // needs only a fresh settle count.
          if (cont) begin
            cnt <= '0;
          end
        end

        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_seq.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_seq
//
// Self-checking bench for mux_scan_seq. It uses two instances: one with
// SETTLE=2 and one with SETTLE=1. Each mux is a behavioural 4:1 mux that
// selects bit sel of a driven 4-bit input word. The expected snapshot is the
// word presented on the sampling cycles. The expected change flag comes from
// a small model that remembers the last published word.
// -----------------------------------------------------------------------------
module tb_mux_scan_seq;

  logic       clk;
  logic       rst;
  logic       start, cont;
  logic [3:0] i;
  logic       mux_o;
  logic [1:0] sel;
  logic [3:0] data;
  logic       valid, changed, busy;

  logic       start2, cont2;
  logic [3:0] i2;
  logic       mux_o2;
  logic [1:0] sel2;
  logic [3:0] data2;
  logic       valid2, changed2, busy2;

  int checks = 0;
  int errors = 0;

  // Reference model state: the last published snapshot, if one exists.
  logic [3:0] prev_data;
  bit         have_prev;

  mux_scan_seq #(.SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .mux_o(mux_o),
    .sel(sel), .data(data), .valid(valid), .changed(changed), .busy(busy)
  );

  mux_scan_seq #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start2), .cont(cont2), .mux_o(mux_o2),
    .sel(sel2), .data(data2), .valid(valid2), .changed(changed2), .busy(busy2)
  );

  // Behavioural 4:1 muxes.
  assign mux_o  = i[sel];
  assign mux_o2 = i2[sel2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; cont = 1'b0; start2 = 1'b0; cont2 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    have_prev = 1'b0;
    prev_data = 4'b0000;
  endtask

  // Called right after the edge that accepted start (E0) on the SETTLE=2
  // instance. It checks 12 cycles of scanning, then the DONE cycle, and
  // returns inside the DONE cycle. The DONE-closing edge is left to the caller.
  // glitch: the mux input is randomised on every non-sampling cycle.
  // pulse_at / drop_at: edge numbers (relative to E0) at which start is
  // pulsed or cont is dropped; -1 disables.
  task automatic expect_frame(input logic [3:0] word, input bit glitch,
                              input int pulse_at, input int drop_at,
                              input string tag);
    logic [3:0] exp_d;
    logic       exp_c;
    exp_d     = word;
    exp_c     = have_prev && (word != prev_data);
    prev_data = word;
    have_prev = 1'b1;
    for (int c = 0; c < 12; c++) begin
      start = (c == pulse_at - 1);
      if (c == drop_at - 1) cont = 1'b0;
      i = (glitch && (c % 3 != 2)) ? 4'($urandom) : word;
      checks++;
      if (sel !== 2'(c / 3)) begin
        errors++;
        $display("FAIL %s sel cycle %0d: got %0d want %0d", tag, c, sel, c / 3);
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy cycle %0d: got %b want 1", tag, c, busy);
      end
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("FAIL %s early valid cycle %0d: got %b want 0", tag, c, valid);
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL %s valid: got %b want 1", tag, valid);
    end
    checks++;
    if (data !== exp_d) begin
      errors++;
      $display("FAIL %s data: got %b want %b", tag, data, exp_d);
    end
    checks++;
    if (changed !== exp_c) begin
      errors++;
      $display("FAIL %s changed: got %b want %b", tag, changed, exp_c);
    end
    checks++;
    if (busy !== 1'b1 || sel !== 2'd0) begin
      errors++;
      $display("FAIL %s done busy/sel: got %b/%0d want 1/0", tag, busy, sel);
    end
  endtask

  // After the DONE-closing edge with cont=0 the block must be idle.
  task automatic expect_idle(input string tag);
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || sel !== 2'd0) begin
      errors++;
      $display("FAIL %s idle busy/valid/sel: got %b/%b/%0d want 0/0/0",
               tag, busy, valid, sel);
    end
  endtask

  task automatic test_reset();
    i = 4'b0000; i2 = 4'b0000;
    do_reset();
    checks++;
    if ({sel, data, valid, changed, busy} !== 9'd0) begin
      errors++;
      $display("FAIL reset dut2 sel/data/valid/changed/busy: got %0d/%b/%b/%b/%b want all 0",
               sel, data, valid, changed, busy);
    end
    checks++;
    if ({sel2, data2, valid2, changed2, busy2} !== 9'd0) begin
      errors++;
      $display("FAIL reset dut1 sel/data/valid/changed/busy: got %0d/%b/%b/%b/%b want all 0",
               sel2, data2, valid2, changed2, busy2);
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    i = 4'b1010;
    start = 1'b1;
    tick();  // E0
    expect_frame(4'b1010, 1'b0, -1, -1, "single");
    tick();  // E13
    expect_idle("single");
    // Further idle cycles stay quiet.
    tick();
    expect_idle("single_hold");
  endtask

  task automatic test_continuous();
    logic [3:0] words [7];
    do_reset();
    words[0] = 4'b1010; words[1] = 4'b1010; words[2] = 4'b0110;
    for (int k = 3; k < 7; k++) words[k] = 4'($urandom);
    cont  = 1'b1;
    start = 1'b1;
    tick();  // E0 of frame 0
    for (int k = 0; k < 7; k++) begin
      expect_frame(words[k], 1'b0, -1, (k == 6) ? 7 : -1, $sformatf("cont%0d", k));
      tick();  // DONE-closing edge: next frame's E0, or return to idle
    end
    expect_idle("cont_end");
  endtask

  task automatic test_start_ignored();
    do_reset();
    start = 1'b1;
    tick();  // E0
    // A second start at E5 must neither restart nor queue a frame.
    expect_frame(4'($urandom), 1'b0, 5, -1, "restart");
    tick();
    expect_idle("restart");
    tick();
    expect_idle("restart_noqueue");
  endtask

  task automatic test_cont_drop();
    do_reset();
    cont  = 1'b1;
    start = 1'b1;
    tick();  // E0
    expect_frame(4'($urandom), 1'b0, -1, -1, "drop_f1");
    tick();  // E13
    // cont falls at E20; frame 2 still completes (valid after E25).
    expect_frame(4'($urandom), 1'b0, -1, 7, "drop_f2");
    tick();  // E26
    expect_idle("drop");
  endtask

  task automatic test_reset_mid();
    logic [3:0] w;
    do_reset();
    // Publish a non-zero snapshot so that the data reset can be seen.
    w = 4'($urandom) | 4'b0001;
    start = 1'b1;
    tick();
    expect_frame(w, 1'b0, -1, -1, "pre_rst");
    tick();
    start = 1'b1;
    tick();  // E0
    start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      i = 4'($urandom);
      tick();
    end
    // Now just after E7. Reset is sampled at E8.
    rst = 1'b1;
    tick();
    checks++;
    if (sel !== 2'd0 || busy !== 1'b0 || valid !== 1'b0 || data !== 4'd0 ||
        changed !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst sel/busy/valid/data/changed: got %0d/%b/%b/%b/%b want 0/0/0/0000/0",
               sel, busy, valid, data, changed);
    end
    rst = 1'b0;
    have_prev = 1'b0;
    prev_data = 4'b0000;
    start = 1'b1;
    tick();  // E0 of a fresh frame, no previous snapshot
    expect_frame(4'($urandom), 1'b0, -1, -1, "post_rst");
    tick();
    expect_idle("post_rst");
  endtask

  task automatic test_glitch();
    do_reset();
    // The mux input is noisy on every settle cycle and stable only on sampling cycles.
    for (int k = 0; k < 3; k++) begin
      start = 1'b1;
      tick();
      expect_frame(4'($urandom), 1'b1, -1, -1, $sformatf("glitch%0d", k));
      tick();
      expect_idle("glitch");
    end
  endtask

  task automatic test_settle1();
    logic [3:0] words [3];
    logic [3:0] prev;
    words[0] = 4'b0001; words[1] = 4'($urandom); words[2] = 4'b0001;
    do_reset();
    prev = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      i2 = words[k];
      start2 = 1'b1;
      tick();  // E0
      start2 = 1'b0;
      for (int c = 0; c < 8; c++) begin
        checks++;
        if (sel2 !== 2'(c / 2) || valid2 !== 1'b0 || busy2 !== 1'b1) begin
          errors++;
          $display("FAIL s1_f%0d cycle %0d sel/valid/busy: got %0d/%b/%b want %0d/0/1",
                   k, c, sel2, valid2, busy2, c / 2);
        end
        tick();
      end
      checks++;
      if (valid2 !== 1'b1 || data2 !== words[k]) begin
        errors++;
        $display("FAIL s1_f%0d valid/data: got %b/%b want 1/%b", k, valid2, data2, words[k]);
      end
      checks++;
      if (changed2 !== ((k > 0) && (words[k] != prev))) begin
        errors++;
        $display("FAIL s1_f%0d changed: got %b want %b", k, changed2,
                 (k > 0) && (words[k] != prev));
      end
      prev = words[k];
      tick();
      checks++;
      if (busy2 !== 1'b0 || valid2 !== 1'b0) begin
        errors++;
        $display("FAIL s1_f%0d idle busy/valid: got %b/%b want 0/0", k, busy2, valid2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_continuous();
    test_start_ignored();
    test_cont_drop();
    test_reset_mid();
    test_glitch();
    test_settle1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
